// File: rtl/multi_gate_checker.sv
// Exhaustive-sweep checker for NUM_GATES identical NUM_INPUTS-input logic gates.
// Optional CHECKER_LOOP_EN: holding start through REPORT chains back-to-back sweeps.
module multi_gate_checker #(
    parameter int NUM_GATES     = 4,
    parameter int NUM_INPUTS    = 2,
    parameter int SETTLE_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            gateSelect,
    input  logic [NUM_GATES-1:0]  op,
    output logic [NUM_INPUTS-1:0] A,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_GATES-1:0]  pass_vec,
    output logic [NUM_GATES-1:0]  fail_vec,
    output logic                  pass,
    output logic                  fail,
    output logic                  sel_err
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [NUM_INPUTS:0]   PAT_LAST = {1'b0, {NUM_INPUTS{1'b1}}};

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_INPUTS:0]   pattern_q, pattern_d;
    logic [2:0]            sel_q, sel_d;
    logic [NUM_GATES-1:0]  mism_q, mism_d;
    logic [NUM_GATES-1:0]  pass_vec_q, pass_vec_d, fail_vec_q, fail_vec_d;
    logic                  pass_q, pass_d, fail_q, fail_d;
    logic                  sel_err_q, sel_err_d, done_q, done_d;
    logic                  gold_w;

    function automatic logic sel_valid(input logic [2:0] s);
        return (s != 3'd6) && (s != 3'd7);
    endfunction

    function automatic logic golden(input logic [2:0] s, input logic [NUM_INPUTS-1:0] pat);
        case (s)
            3'd0:    return &pat;
            3'd1:    return |pat;
            3'd2:    return ~&pat;
            3'd3:    return ~|pat;
            3'd4:    return ^pat;
            3'd5:    return ~^pat;
            default: return 1'b0;
        endcase
    endfunction

    assign gold_w = golden(sel_q, pattern_q[NUM_INPUTS-1:0]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pattern_d  = pattern_q;
        sel_d      = sel_q;
        mism_d     = mism_q;
        pass_vec_d = pass_vec_q;
        fail_vec_d = fail_vec_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        sel_err_d  = sel_err_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d     = gateSelect;
                    mism_d    = '0;
                    pattern_d = '0;
                    cnt_d     = '0;
                    state_d   = sel_valid(gateSelect) ? SETTLE : REPORT;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                for (int i = 0; i < NUM_GATES; i++) begin
                    mism_d[i] = mism_q[i] | (op[i] != gold_w);
                end
                if (pattern_q == PAT_LAST) begin
                    state_d = REPORT;
                end else begin
                    pattern_d = pattern_q + {{NUM_INPUTS{1'b0}}, 1'b1};
                    cnt_d     = '0;
                    state_d   = SETTLE;
                end
            end
            REPORT: begin
                done_d = 1'b1;
                if (sel_valid(sel_q)) begin
                    pass_vec_d = ~mism_q;
                    fail_vec_d = mism_q;
                    pass_d     = ~|mism_q;
                    fail_d     = |mism_q;
                    sel_err_d  = 1'b0;
                end else begin
                    pass_vec_d = '0;
                    fail_vec_d = '1;
                    pass_d     = 1'b0;
                    fail_d     = 1'b1;
                    sel_err_d  = 1'b1;
                end
                // A parks at 0 between sweeps so the socket sees a known pattern
                pattern_d = '0;
                cnt_d     = '0;
                state_d   = IDLE;
`ifdef CHECKER_LOOP_EN
                if (start) begin
                    sel_d   = gateSelect;
                    mism_d  = '0;
                    state_d = sel_valid(gateSelect) ? SETTLE : REPORT;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pattern_q  <= '0;
            pass_vec_q <= '0;
            fail_vec_q <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            sel_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pattern_q  <= pattern_d;
            pass_vec_q <= pass_vec_d;
            fail_vec_q <= fail_vec_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            sel_err_q  <= sel_err_d;
            done_q     <= done_d;
        end
    end

    // Selection and mismatch are always rewritten on an accepted start
    always_ff @(posedge clk) begin
        sel_q  <= sel_d;
        mism_q <= mism_d;
    end

    assign A        = pattern_q[NUM_INPUTS-1:0];
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign pass_vec = pass_vec_q;
    assign fail_vec = fail_vec_q;
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_multi_gate_checker.sv
// Bench for multi_gate_checker: cycle-count reference model, directed tests and random sweeps.
module tb_multi_gate_checker;

    localparam int NG  = 4;
    localparam int NI  = 2;
    localparam int S   = 4;
    localparam int P   = 1 << NI;
    localparam int NG1 = 2;
    localparam int NI1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, start1, cmp_en;
    logic [2:0]     gs, gs1, drv_sel;
    logic [NG-1:0]  op0, stuck_en, stuck_val, flip;
    logic [NI-1:0]  A0;
    logic           busy0, done0, pass0, fail0, serr0;
    logic [NG-1:0]  pv0, fv0;
    logic [NG1-1:0] op1, pv1, fv1;
    logic [NI1-1:0] A1;
    logic           busy1, done1, pass1, fail1, serr1;

    int checks = 0;
    int errors = 0;

    multi_gate_checker #(.NUM_GATES(NG), .NUM_INPUTS(NI), .SETTLE_CYCLES(S)) dut0 (
        .clk(clk), .rst(rst), .start(start), .gateSelect(gs), .op(op0), .A(A0),
        .busy(busy0), .done(done0), .pass_vec(pv0), .fail_vec(fv0),
        .pass(pass0), .fail(fail0), .sel_err(serr0));

    multi_gate_checker #(.NUM_GATES(NG1), .NUM_INPUTS(NI1), .SETTLE_CYCLES(S)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .gateSelect(gs1), .op(op1), .A(A1),
        .busy(busy1), .done(done1), .pass_vec(pv1), .fail_vec(fv1),
        .pass(pass1), .fail(fail1), .sel_err(serr1));

    // Golden gate value from the count of ones in the pattern
    function automatic logic gold(input int sel, input int pat, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += (pat >> i) & 1;
        case (sel)
            0:       return ones == n;
            1:       return ones != 0;
            2:       return ones != n;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            5:       return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always_comb begin
        op0 = '0;
        for (int i = 0; i < NG; i++)
            op0[i] = stuck_en[i] ? stuck_val[i] : (gold(int'(drv_sel), int'(A0), NI) ^ flip[i]);
    end

    always_comb begin
        op1 = '0;
        for (int i = 0; i < NG1; i++) op1[i] = gold(4, int'(A1), NI1);
    end

    // Reference model: m_k counts cycles since the accepting edge
    logic          m_active, m_done, m_pass, m_fail, m_serr;
    int            m_k, m_dur, m_sel;
    logic [NG-1:0] m_mism, m_pv, m_fv;

    function automatic int dur_of(input int sel);
        return (sel >= 6) ? 1 : P * (S + 1) + 1;
    endfunction

    function automatic int exp_a();
        if (!m_active || m_sel >= 6) return 0;
        if (m_k <= P * (S + 1)) return (m_k - 1) / (S + 1);
        return P - 1;
    endfunction

    initial begin
        m_active = 1'b0; m_done = 1'b0; m_k = 0; m_dur = 0; m_sel = 0;
        m_mism = '0; m_pv = '0; m_fv = '0; m_pass = 1'b0; m_fail = 1'b0; m_serr = 1'b0;
        forever begin
            @(posedge clk);
            m_done = 1'b0;
            if (rst) begin
                m_active = 1'b0; m_k = 0;
                m_pv = '0; m_fv = '0; m_pass = 1'b0; m_fail = 1'b0; m_serr = 1'b0;
            end else if (m_active) begin
                if (m_sel < 6 && (m_k % (S + 1)) == 0 && m_k <= P * (S + 1))
                    for (int i = 0; i < NG; i++)
                        if (op0[i] !== gold(m_sel, m_k / (S + 1) - 1, NI)) m_mism[i] = 1'b1;
                if (m_k == m_dur) begin
                    m_done = 1'b1;
                    if (m_sel < 6) begin
                        m_pv = ~m_mism; m_fv = m_mism;
                        m_pass = (m_mism == '0); m_fail = (m_mism != '0); m_serr = 1'b0;
                    end else begin
                        m_pv = '0; m_fv = '1; m_pass = 1'b0; m_fail = 1'b1; m_serr = 1'b1;
                    end
                    m_active = 1'b0;
`ifdef CHECKER_LOOP_EN
                    if (start) begin
                        m_active = 1'b1; m_sel = int'(gs); m_mism = '0; m_k = 1; m_dur = dur_of(m_sel);
                    end
`endif
                end else begin
                    m_k++;
                end
            end else if (start) begin
                m_active = 1'b1; m_sel = int'(gs); m_mism = '0; m_k = 1; m_dur = dur_of(m_sel);
            end
        end
    end

    // Single compare process against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("A", A0, exp_a());
                check("busy", busy0, m_active);
                check("done", done0, m_done);
                check("pass_vec", pv0, m_pv);
                check("fail_vec", fv0, m_fv);
                check("pass", pass0, m_pass);
                check("fail", fail0, m_fail);
                check("sel_err", serr0, m_serr);
                check("pass_and_fail", pass0 & fail0, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Pulse start from IDLE and return the edges from acceptance until done is seen
    task automatic do_sweep(input logic [2:0] sel, output int lat);
        gs = sel;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int e = 0; e <= 200; e++) begin
            if (done0) begin
                lat = e;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; gs = 3'd0; gs1 = 3'd4; cmp_en = 1'b0;
        drv_sel = 3'd0; stuck_en = '0; stuck_val = '0; flip = '0;
        repeat (3) @(negedge clk);
        check("rst_A", A0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pv", pv0, 0);
        check("rst_fv", fv0, 0);
        check("rst_pass_fail_err", {pass0, fail0, serr0}, 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // AND, all gates correct
        drv_sel = 3'd0;
        do_sweep(3'd0, lat);
        check("and_latency", lat, 21);
        check("and_pv", pv0, 4'b1111);
        check("and_pass", pass0, 1);
        check("and_fail", fail0, 0);
        @(negedge clk);

        // NAND, gate 2 stuck at 0
        drv_sel = 3'd2; stuck_en = 4'b0100; stuck_val = 4'b0000;
        do_sweep(3'd2, lat);
        check("nand_latency", lat, 21);
        check("nand_pv", pv0, 4'b1011);
        check("nand_fv", fv0, 4'b0100);
        check("nand_pass", pass0, 0);
        check("nand_fail", fail0, 1);
        stuck_en = '0;
        @(negedge clk);

        // Invalid selection: REPORT entered directly, done on the following edge
        do_sweep(3'd6, lat);
        check("inv_latency", lat, 1);
        check("inv_sel_err", serr0, 1);
        check("inv_fv", fv0, 4'b1111);
        check("inv_fail", fail0, 1);
        check("inv_A", A0, 0);
        @(negedge clk);

        // Reset during pattern 2 with a fault seen in pattern 0, then a clean OR sweep
        drv_sel = 3'd1; stuck_en = 4'b0010; stuck_val = 4'b0010;
        gs = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int e = 0; e <= 100; e++) begin
            if (A0 == 2'd2) begin
                lat = e;
                break;
            end
            @(negedge clk);
        end
        check("rst_reach_pat2", lat, 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy0, 0);
        check("midrst_A", A0, 0);
        check("midrst_pv_fv", {pv0, fv0}, 0);
        check("midrst_flags", {pass0, fail0, serr0, done0}, 0);
        stuck_en = '0;
        do_sweep(3'd1, lat);
        check("or_latency", lat, 21);
        check("or_pv", pv0, 4'b1111);
        check("or_pass", pass1 | pass0, 1);
        @(negedge clk);

        // 3-input XOR on the second instance: A steps 0..7, 5 cycles each
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = -1;
        for (int e = 0; e <= 80; e++) begin
            if (done1) begin
                lat = e;
                break;
            end
            check("xor_A", A1, (e < 40) ? e / 5 : 7);
            @(negedge clk);
        end
        check("xor_latency", lat, 41);
        check("xor_pass", pass1, 1);
        check("xor_pv", pv1, 2'b11);
        @(negedge clk);

        // Randomized traffic, including starts while busy and occasional reset
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            flip  = ($urandom_range(0, 15) == 0) ? NG'($urandom) : '0;
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 9) == 0);
            gs    = 3'($urandom_range(0, 7));
            if (start) drv_sel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 5)) : gs;
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; flip = '0;
        repeat (60) @(negedge clk);
        check("rand_idle", busy0, 0);

`ifdef CHECKER_LOOP_EN
        drv_sel = 3'd0; gs = 3'd0; start = 1'b1;
        lat = -1;
        for (int e = 0; e <= 200; e++) begin
            @(negedge clk);
            if (done0) begin
                lat = e;
                break;
            end
        end
        check("loop1_seen", lat, 21);
        check("loop1_pass", pass0, 1);
        stuck_en = 4'b0001; stuck_val = 4'b0000;
        lat = -1;
        for (int e = 0; e <= 200; e++) begin
            @(negedge clk);
            check("loop_busy", busy0, 1);
            if (done0) begin
                lat = e;
                break;
            end
        end
        check("loop2_seen", lat, 20);
        check("loop2_fv0", fv0[0], 1);
        check("loop2_fail", fail0, 1);
        start = 1'b0; stuck_en = '0;
        repeat (30) @(negedge clk);
        check("loop_end_idle", busy0, 0);
        check("loop3_pass", pass0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
